// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the adder arbiter.
// Optional overflow flag: define ADDER_OVF_EN.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 3;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters and the shared adder.
// Optional overflow flag: define ADDER_OVF_EN.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  busy;
`ifdef ADDER_OVF_EN
  logic                  rsp_ovf;
`endif

  modport master (
    output req_valid,
    output req_in1,
    output req_in2,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_sum,
    input  busy
`ifdef ADDER_OVF_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req_valid,
    input  req_in1,
    input  req_in2,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_sum,
    output busy
`ifdef ADDER_OVF_EN
    , output rsp_ovf
`endif
  );

endinterface

// File: rtl/adder_rr_picker.sv
// Rotating-priority pick: first valid requester at or after rr_ptr.
// Optional overflow flag elsewhere: ADDER_OVF_EN (not used here).
module adder_rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  grant,
  output logic            any_valid
);

  int idx;

  // scan far-to-near so the nearest valid slot wins
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant     = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One shared adder, round-robin among requesters, registered sum.
// Optional signed-overflow flag: define ADDER_OVF_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic          clk,
  input logic          rst_n,
  adder_arbiter_if.slave bus
);
  localparam int IDW = id_w(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic [NREQ-1:0]  req_ready;

  adder_rr_picker #(.NREQ(NREQ)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // next-state, operand capture and add
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rsp_id_d  = rsp_id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          a_d     = bus.req_in1[int'(grant)*WIDTH +: WIDTH];
          b_d     = bus.req_in2[int'(grant)*WIDTH +: WIDTH];
          grant_d = grant;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d    = a_q + b_q;
        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        rsp_id_d = grant_q;
        rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ?
                   '0 : grant_q + 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rsp_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rsp_id_q <= rsp_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = sum_q;
`ifdef ADDER_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: vector table, corner sequences, random vs model.
// Overflow checks compiled in with ADDER_OVF_EN.
module tb_adder_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic clk;
  logic rst_n;

  adder_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

  adder_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int ptr_m;

  typedef struct packed {
    logic [2:0]        v;
    logic [2:0][31:0]  a;
    logic [2:0][31:0]  b;
    int                hold;
    int                id;
    logic [31:0]       sum;
    logic              ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // spec rule: first valid index at or after the pointer, wrapping
  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // one transaction from IDLE; caller is just after a posedge
  task automatic run_txn(input logic [2:0] v,
                         input logic [2:0][31:0] a,
                         input logic [2:0][31:0] b,
                         input int hold, input logic [2:0] glitch,
                         input int exp_id, input logic [31:0] exp_sum,
                         input logic exp_ovf);
    logic [2:0] one;
    one = 3'b001 << exp_id;
    bus.req_valid = v;
    bus.req_in1   = a;
    bus.req_in2   = b;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("accept_ready", 64'(bus.req_ready), 64'(one));
    chk("idle_busy", 64'(bus.busy), 64'd0);
    step();
    bus.req_valid = v | glitch;
    @(negedge clk);
    chk("add_ready", 64'(bus.req_ready), 64'd0);
    chk("add_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    bus.req_valid = v;
    @(negedge clk);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rsp_sum", 64'(bus.rsp_sum), 64'(exp_sum));
    chk("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
`ifdef ADDER_OVF_EN
    chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x");
`endif
    for (int h = 0; h < hold; h++) begin
      step();
      @(negedge clk);
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_sum", 64'(bus.rsp_sum), 64'(exp_sum));
      chk("stall_id", 64'(bus.rsp_id), 64'(exp_id));
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    ptr_m = (exp_id + 1) % N;
  endtask

  initial begin
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
    logic [2:0]       v;
    int               g;
    longint           s;
    longint           ss;
    n_chk  = 0;
    n_fail = 0;
    ptr_m  = 0;

    tbl[0] = '{v:3'b001, a:{32'd0, 32'd0, 32'd2},
               b:{32'd0, 32'd0, 32'd20}, hold:0, id:0,
               sum:32'd22, ovf:1'b0};
    tbl[1] = '{v:3'b111, a:{32'd1000, 32'd100, 32'd10},
               b:{32'd3, 32'd2, 32'd1}, hold:1, id:1,
               sum:32'd102, ovf:1'b0};
    tbl[2] = '{v:3'b111, a:{32'd1000, 32'd100, 32'd10},
               b:{32'd3, 32'd2, 32'd1}, hold:0, id:2,
               sum:32'd1003, ovf:1'b0};
    tbl[3] = '{v:3'b111, a:{32'd1000, 32'd100, 32'd10},
               b:{32'd3, 32'd2, 32'd1}, hold:2, id:0,
               sum:32'd11, ovf:1'b0};
    tbl[4] = '{v:3'b111, a:{32'd1000, 32'd100, 32'd10},
               b:{32'd3, 32'd2, 32'd1}, hold:5, id:1,
               sum:32'd102, ovf:1'b0};
    tbl[5] = '{v:3'b001, a:{32'd0, 32'd0, 32'hFFFF_FFFF},
               b:{32'd0, 32'd0, 32'd1}, hold:0, id:0,
               sum:32'd0, ovf:1'b0};
    tbl[6] = '{v:3'b001, a:{32'd0, 32'd0, 32'h7FFF_FFFF},
               b:{32'd0, 32'd0, 32'd1}, hold:0, id:0,
               sum:32'h8000_0000, ovf:1'b1};
    tbl[7] = '{v:3'b100, a:{32'd5, 32'd0, 32'd0},
               b:{32'd6, 32'd0, 32'd0}, hold:1, id:2,
               sum:32'd11, ovf:1'b0};
    tbl[8] = '{v:3'b010, a:{32'd0, 32'h8000_0000, 32'd0},
               b:{32'd0, 32'h8000_0000, 32'd0}, hold:0, id:1,
               sum:32'd0, ovf:1'b1};
    tbl[9] = '{v:3'b011, a:{32'd0, 32'd9, 32'd3},
               b:{32'd0, 32'd9, 32'd4}, hold:0, id:0,
               sum:32'd7, ovf:1'b0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sum", 64'(bus.rsp_sum), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].hold, 3'b000,
              tbl[i].id, tbl[i].sum, tbl[i].ovf);

    // requester 1 pulses valid while busy, then withdraws
    a = {32'd0, 32'd0, 32'd40};
    b = {32'd0, 32'd0, 32'd2};
    run_txn(3'b001, a, b, 0, 3'b010, 0, 32'd42, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wd_idle_ready", 64'(bus.req_ready), 64'd0);
      chk("wd_idle_busy", 64'(bus.busy), 64'd0);
      step();
    end
    a = {32'd8, 32'd0, 32'd1};
    b = {32'd8, 32'd0, 32'd1};
    run_txn(3'b101, a, b, 0, 3'b000, 2, 32'd16, 1'b0);

    // reset while holding a response
    bus.req_valid = 3'b001;
    bus.req_in1   = {32'd0, 32'd0, 32'd9};
    bus.req_in2   = {32'd0, 32'd0, 32'd9};
    step();
    step();
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.rsp_sum), 64'd0);
    chk("mid_rst_id", 64'(bus.rsp_id), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
`ifdef ADDER_OVF_EN
    chk("mid_rst_ovf", 64'(bus.rsp_ovf), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    ptr_m = 0;
    step();
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    a = {32'd0, 32'd5, 32'd1};
    b = {32'd0, 32'd5, 32'd1};
    run_txn(3'b011, a, b, 0, 3'b000, 0, 32'd2, 1'b0);

    // random traffic against the arithmetic model
    for (int t = 0; t < 40; t++) begin
      v = 3'($urandom_range(1, 7));
      for (int k = 0; k < N; k++) begin
        a[k] = $urandom;
        b[k] = $urandom;
      end
      g  = pick(v, ptr_m);
      s  = longint'(a[g]) + longint'(b[g]);
      ss = longint'($signed(a[g])) + longint'($signed(b[g]));
      run_txn(v, a, b, int'($urandom_range(0, 3)), 3'b000, g,
              s[31:0],
              (ss > 64'sd2147483647) || (ss < -64'sd2147483648));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
